apb_master_ctrl: RTL
====================

# apb_master_ctrl

APB requester for the bridge: accepts single read/write commands from the bridge core, decodes the address onto one of four `PSELx` lines and runs a SETUP/ENABLE APB transfer. It drives the same APB signal set that the APB slave-side agents respond to, and returns read data or a decode error to the core. A one-entry command buffer lets a new transfer follow directly after the previous one.

## Interface
- `ADDR_W`, 32: width of `PADDR` and `cmd_addr`.
- `DATA_W`, 32: width of `PWDATA`, `PRDATA`, `cmd_wdata`, `rsp_rdata`.

Ports:
- `clock` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `cmd_valid` input 1: command offered.
- `cmd_ready` output 1: buffer empty; the command is accepted when `cmd_valid && cmd_ready` at a clock edge.
- `cmd_write` input 1: 1 = write, 0 = read.
- `cmd_addr` input ADDR_W: byte address.
- `cmd_wdata` input DATA_W: write data.
- `rsp_valid` output 1: one-cycle pulse, one per accepted command; no backpressure.
- `rsp_err` output 1: decode miss, qualified by `rsp_valid`.
- `rsp_rdata` output DATA_W: read data; 0 for writes and errors.
- `PSELx` output 4: one-hot slave select.
- `PENABLE` output 1: APB enable phase.
- `PWRITE` output 1: APB direction.
- `PADDR` output ADDR_W: APB address.
- `PWDATA` output DATA_W: APB write data.
- `PRDATA` input DATA_W: APB read data, sampled at the end of ENABLE.

## Operation
- Address decode uses `cmd_addr[31:26]`:
  - 0x20 → `PSELx=4'b0001` (0x8000_0000–0x83FF_FFFF).
  - 0x21 → `4'b0010`.
  - 0x22 → `4'b0100`.
  - 0x23 → `4'b1000`.
  - Any other value → decode miss.
- Buffer: one register for {write, addr, wdata}. `cmd_ready = ~buf_valid`. The buffer is cleared when the FSM consumes it.
- FSM states are IDLE, SETUP and ENABLE.
  - IDLE, `buf_valid`, decode hit → SETUP. Load `PADDR`, `PWRITE`, `PWDATA` and `PSELx` from the buffer; `PENABLE=0`; clear the buffer.
  - IDLE, `buf_valid`, decode miss → stay in IDLE. Clear the buffer and pulse `rsp_valid`, `rsp_err=1`, `rsp_rdata=0` at the next edge. No APB activity.
  - SETUP → ENABLE unconditionally; `PENABLE=1`, all other APB outputs held.
  - ENABLE ends the transfer. Fixed one enable cycle (no PREADY). Pulse `rsp_valid`, `rsp_err=0`; `rsp_rdata` = `PRDATA` for reads, 0 for writes.
    - Buffer holds a decode hit → SETUP directly. Load the new command; `PSELx` switches to the new decode and `PENABLE=0`.
    - Otherwise (empty, or decode miss) → IDLE with `PSELx=0` and `PENABLE=0`. A buffered miss is handled from IDLE on the following edge.
- `PADDR`, `PWRITE`, `PWDATA` hold their last values in IDLE. `PSELx` and `PENABLE` are 0 in IDLE.
- Responses are returned in command order.

## Timing
- Reset (async, immediate) values:
  - FSM = IDLE, buffer empty, `cmd_ready=1`.
  - `rsp_valid=0`, `rsp_err=0`, `rsp_rdata=0`.
  - `PSELx=0`, `PENABLE=0`, `PWRITE=0`, `PADDR=0`, `PWDATA=0`.
- Reset mid-transfer: the transfer is dropped, no response is issued, and the buffered command is lost.
- Single command accepted at edge N:
  - `buf_valid=1` after N.
  - SETUP after N+1; `cmd_ready` is 1 again after N+1.
  - ENABLE after N+2.
  - `rsp_valid=1` for the cycle after N+3, with `PRDATA` sampled at edge N+3.
- Read latency: 3 cycles from acceptance to response.
- Back-to-back: a second command accepted at edge N+2 enters SETUP at N+3. Sustained throughput is one transfer per 2 cycles with no idle cycle between transfers.
- Decode miss accepted at N: `rsp_valid`/`rsp_err` high for the cycle after N+2.
- All outputs are registered; none depend combinationally on inputs except `cmd_ready`, which depends only on state.

## Test plan
- After reset, write 0x8000_0010 with data 0xDEAD_BEEF:
  - SETUP: `PSELx=0001`, `PWRITE=1`, `PENABLE=0`.
  - Next cycle: `PENABLE=1`.
  - Then `rsp_valid` pulse with `rsp_err=0`, `rsp_rdata=0`; `PSELx` returns to 0.
- Read 0x8C00_0004 with the APB model driving `PRDATA=0x1234_5678`: `PSELx=1000`, `PWRITE=0`, response `rsp_rdata=0x1234_5678` 3 cycles after acceptance.
- Back-to-back: write 0x8400_0000, then read 0x8800_0000 presented while `cmd_ready` is high.
  - Second SETUP follows the first ENABLE with no IDLE cycle; `PSELx` goes 0010 → 0100.
  - Two `rsp_valid` pulses, 2 cycles apart.
- Read 0x9000_0000 (decode miss): `PSELx`/`PENABLE` stay 0; `rsp_valid=1`, `rsp_err=1`, `rsp_rdata=0` 2 cycles after acceptance.
- Assert `reset` during ENABLE of a read: all outputs go to their reset values immediately with no response; a command issued after reset completes normally.
- `cmd_valid` held high continuously while the buffer is full: `cmd_ready=0` while the buffer is occupied; no command is dropped or duplicated; the response count equals the accepted-command count.

Source files
------------

// File: rtl/apb_master_ctrl_if.sv
// Command/response and APB bus bundle between the bridge core, the APB requester
// and the APB completers.
interface apb_master_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  logic [3:0]        PSELx;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA,
    output cmd_ready, rsp_valid, rsp_err, rsp_rdata,
           PSELx, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA,
    input  cmd_ready, rsp_valid, rsp_err, rsp_rdata,
           PSELx, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_master_ctrl.sv
// APB requester: one-entry command buffer, 4-way address decode and a
// SETUP/ENABLE transfer FSM returning read data or a decode error in order.
module apb_master_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  apb_master_ctrl_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ENABLE = 2'd2
  } state_t;

  state_t            state;
  logic              buf_valid;
  logic              buf_write;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_wdata;
  logic              miss_pend;
  logic [3:0]        buf_sel;

  // Top six address bits pick one of four 64 MB completer windows at 0x8000_0000.
  function automatic logic [3:0] decode(input logic [ADDR_W-1:0] a);
    case (a[ADDR_W-1 -: 6])
      6'h20:   decode = 4'b0001;
      6'h21:   decode = 4'b0010;
      6'h22:   decode = 4'b0100;
      6'h23:   decode = 4'b1000;
      default: decode = 4'b0000;
    endcase
  endfunction

  assign buf_sel       = decode(buf_addr);
  assign bus.cmd_ready = ~buf_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      buf_valid     <= 1'b0;
      buf_write     <= 1'b0;
      buf_addr      <= '0;
      buf_wdata     <= '0;
      miss_pend     <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.PSELx     <= 4'b0000;
      bus.PENABLE   <= 1'b0;
      bus.PWRITE    <= 1'b0;
      bus.PADDR     <= '0;
      bus.PWDATA    <= '0;
    end else begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= '0;
      miss_pend     <= 1'b0;

      // A decode miss seen in IDLE answers one edge later.
      if (miss_pend) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_err   <= 1'b1;
      end

      if (bus.cmd_valid && !buf_valid) begin
        buf_valid <= 1'b1;
        buf_write <= bus.cmd_write;
        buf_addr  <= bus.cmd_addr;
        buf_wdata <= bus.cmd_wdata;
      end

      case (state)
        IDLE: begin
          if (buf_valid) begin
            buf_valid <= 1'b0;
            if (buf_sel != 4'b0000) begin
              bus.PSELx   <= buf_sel;
              bus.PENABLE <= 1'b0;
              bus.PWRITE  <= buf_write;
              bus.PADDR   <= buf_addr;
              bus.PWDATA  <= buf_wdata;
              state       <= SETUP;
            end else begin
              miss_pend <= 1'b1;
            end
          end
        end
        SETUP: begin
          bus.PENABLE <= 1'b1;
          state       <= ENABLE;
        end
        ENABLE: begin
          bus.rsp_valid <= 1'b1;
          bus.rsp_rdata <= bus.PWRITE ? '0 : bus.PRDATA;
          // Chain straight into the next SETUP when a decodable command waits.
          if (buf_valid && buf_sel != 4'b0000) begin
            buf_valid   <= 1'b0;
            bus.PSELx   <= buf_sel;
            bus.PENABLE <= 1'b0;
            bus.PWRITE  <= buf_write;
            bus.PADDR   <= buf_addr;
            bus.PWDATA  <= buf_wdata;
            state       <= SETUP;
          end else begin
            bus.PSELx   <= 4'b0000;
            bus.PENABLE <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          bus.PSELx   <= 4'b0000;
          bus.PENABLE <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule
